aclock_disp_scan: RTL and testbench

- Downstream display stage for the alarm clock core. Consumes its BCD time outputs (H_out1..S_out0) and its Alarm flag.
- Drives a 6-digit multiplexed common-anode 7-segment display by time-division scanning.
- Snapshots the time once per scan frame so digits never tear, blanks a leading hour zero, and flashes the whole display while Alarm is high.

---
 rtl/aclock_disp_scan.sv | 158 +++++++++++++++
 tb/tb_aclock_disp_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aclock_disp_scan.sv
//------------------------------------------------------------------------------
// Module   : aclock_disp_scan
// Brief    : 6-digit multiplexed common-anode 7-segment scanner for the alarm
//            clock core, with per-frame snapshot, leading-zero blank and alarm blink.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aclock_disp_scan #(
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 50,
    parameter bit LEAD_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    input  logic [3:0] S_out1,
    input  logic [3:0] S_out0,
    input  logic       Alarm,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int              c_PW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX   = c_PW'(SCAN_DIV - 1);
    localparam int              c_BW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_BW-1:0] c_BLINK_MAX   = c_BW'(BLINK_DIV - 1);
    localparam logic [2:0]      c_IDX_LAST    = 3'd5;
    localparam logic [6:0]      c_SEG_OFF     = 7'b1111111;
    localparam logic [5:0]      c_AN_OFF      = 6'b111111;

    logic [c_PW-1:0]  r_presc;
    logic [2:0]       r_idx;
    logic             r_load_pend;
    logic [5:0][3:0]  r_snap;
    logic             r_alarm_q;
    logic [c_BW-1:0]  r_blink_cnt;
    logic             r_phase_on;
    logic [5:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_tc;
    logic             w_wrap;
    logic [3:0]       w_digit;
    logic             w_lead_blank;
    logic             w_blank;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // The prescaler is frozen during the load cycle so the first frame gets full slots.
    assign w_tc   = !r_load_pend && (r_presc == c_PRESC_MAX);
    assign w_wrap = w_tc && (r_idx == c_IDX_LAST);

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            3'd0:    w_digit = r_snap[0];
            3'd1:    w_digit = r_snap[1];
            3'd2:    w_digit = r_snap[2];
            3'd3:    w_digit = r_snap[3];
            3'd4:    w_digit = r_snap[4];
            3'd5:    w_digit = r_snap[5];
            default: w_digit = 4'd0;
        endcase
    end

    generate
        if (LEAD_BLANK) begin : g_lead_blank
            assign w_lead_blank = (r_idx == c_IDX_LAST) && (r_snap[5] == 4'd0);
        end else begin : g_no_lead_blank
            assign w_lead_blank = 1'b0;
        end
    endgenerate

    // A low registered Alarm overrides the phase immediately so the display relights fast.
    assign w_blank = r_load_pend || (r_alarm_q && !r_phase_on) || w_lead_blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc     <= '0;
            r_idx       <= 3'd0;
            r_load_pend <= 1'b1;
            r_snap      <= '0;
            r_alarm_q   <= 1'b0;
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
            r_an        <= c_AN_OFF;
            r_seg       <= c_SEG_OFF;
            r_dp        <= 1'b1;
        end else begin
            r_alarm_q   <= Alarm;
            r_load_pend <= 1'b0;

            if (r_load_pend || w_wrap) begin
                r_snap <= {{2'b00, H_out1}, H_out0, M_out1, M_out0, S_out1, S_out0};
            end

            if (!r_load_pend) begin
                if (w_tc) begin
                    r_presc <= '0;
                    r_idx   <= (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            if (!r_alarm_q) begin
                r_phase_on  <= 1'b1;
                r_blink_cnt <= '0;
            end else if (w_wrap) begin
                if (r_blink_cnt == c_BLINK_MAX) begin
                    r_phase_on  <= !r_phase_on;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end

            if (w_blank) begin
                r_an  <= c_AN_OFF;
                r_seg <= c_SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(6'd1 << r_idx);
                r_seg <= f_seg(w_digit);
                r_dp  <= !((r_idx == 3'd2) || (r_idx == 3'd4));
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_aclock_disp_scan.sv
//------------------------------------------------------------------------------
// Module   : tb_aclock_disp_scan
// Brief    : Bench for aclock_disp_scan against a frame-level display model,
//            with and without leading-zero blanking.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aclock_disp_scan;

    localparam int c_SD    = 4;
    localparam int c_BD    = 2;
    localparam int c_FRAME = 6 * c_SD;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] h1;
    logic [3:0] h0, m1, m0, s1, s0;
    logic       alarm;
    logic [5:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;

    int checks   = 0;
    int failures = 0;

    // Model state: edges since reset release, wraps seen while alarm held, registered alarm.
    int         n;
    int         w;
    logic       aq;
    logic [3:0] snap [6];

    always #5 clk = ~clk;

    aclock_disp_scan #(.SCAN_DIV(c_SD), .BLINK_DIV(c_BD), .LEAD_BLANK(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .H_out1(h1), .H_out0(h0), .M_out1(m1), .M_out0(m0), .S_out1(s1), .S_out0(s0),
        .Alarm(alarm), .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    aclock_disp_scan #(.SCAN_DIV(c_SD), .BLINK_DIV(c_BD), .LEAD_BLANK(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .H_out1(h1), .H_out0(h0), .M_out1(m1), .M_out0(m0), .S_out1(s1), .S_out0(s0),
        .Alarm(alarm), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;  4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;  4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;  4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;  4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;  4'd9: s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    function automatic int cur_slot();
        return (n >= 2) ? ((n - 2) / c_SD) % 6 : -1;
    endfunction

    task automatic set_time(input int hh, input int mm, input int ss);
        h1 = 2'(hh / 10); h0 = 4'(hh % 10);
        m1 = 4'(mm / 10); m0 = 4'(mm % 10);
        s1 = 4'(ss / 10); s0 = 4'(ss % 10);
    endtask

    task automatic rand_digits();
        h1 = 2'($urandom_range(0, 3));
        h0 = 4'($urandom_range(0, 15));
        m1 = 4'($urandom_range(0, 15));
        m0 = 4'($urandom_range(0, 15));
        s1 = 4'($urandom_range(0, 15));
        s0 = 4'($urandom_range(0, 15));
    endtask

    // One clock: predict outputs from state before the edge, advance model, then compare.
    task automatic tick();
        logic       blank_all, wrap;
        int         slot;
        logic [5:0] one;
        logic [5:0] e_an_a, e_an_b;
        logic [6:0] e_seg_a, e_seg_b;
        logic       e_dp_a, e_dp_b;
        one     = 6'b000001;
        e_an_a  = 6'b111111; e_an_b  = 6'b111111;
        e_seg_a = 7'b1111111; e_seg_b = 7'b1111111;
        e_dp_a  = 1'b1;      e_dp_b  = 1'b1;
        if (reset) begin
            n  = 0;
            w  = 0;
            aq = 1'b0;
        end else begin
            n++;
            blank_all = (n == 1) || (aq && (((w / c_BD) % 2) == 1));
            if (!blank_all) begin
                slot    = cur_slot();
                e_an_b  = ~(one << slot);
                e_seg_b = seg_of(snap[slot]);
                e_dp_b  = !(slot == 2 || slot == 4);
                if (!(slot == 5 && snap[5] == 4'd0)) begin
                    e_an_a = e_an_b; e_seg_a = e_seg_b; e_dp_a = e_dp_b;
                end
            end
            wrap = (n > 1) && (((n - 1) % c_FRAME) == 0);
            if (!aq) w = 0;
            else if (wrap) w++;
            aq = alarm;
            if (n == 1 || wrap) snap = '{s0, s1, m0, m1, h0, {2'b00, h1}};
        end
        @(posedge clk);
        #1;
        chk("an_lead",    {1'b0, an_a}, {1'b0, e_an_a});
        chk("seg_lead",   seg_a,        e_seg_a);
        chk("dp_lead",    {6'd0, dp_a}, {6'd0, e_dp_a});
        chk("an_nolead",  {1'b0, an_b}, {1'b0, e_an_b});
        chk("seg_nolead", seg_b,        e_seg_b);
        chk("dp_nolead",  {6'd0, dp_b}, {6'd0, e_dp_b});
    endtask

    initial begin
        n = 0; w = 0; aq = 1'b0;
        foreach (snap[i]) snap[i] = 4'd0;
        reset = 1'b1;
        alarm = 1'b0;
        rand_digits();
        repeat (3) tick();

        reset = 1'b0;
        set_time(11, 29, 58);
        repeat (2 * c_FRAME + 2) tick();

        set_time(4, 55, 0);
        repeat (2 * c_FRAME) tick();

        // Change seconds mid-frame; the model only picks it up at the next frame.
        set_time(12, 34, 58);
        repeat (c_FRAME) tick();
        for (int i = 0; i < c_FRAME && cur_slot() != 3; i++) tick();
        s0 = 4'd9;
        repeat (c_FRAME + 4) tick();

        // Alarm: run into the OFF phase, then drop it there.
        alarm = 1'b1;
        repeat (5 * c_FRAME) tick();
        for (int i = 0; i < 4 * c_FRAME && !(aq && ((w / c_BD) % 2) == 1); i++) tick();
        repeat (5) tick();
        alarm = 1'b0;
        repeat (c_FRAME) tick();

        m0 = 4'd12;
        repeat (c_FRAME + 2) tick();

        for (int i = 0; i < c_FRAME && cur_slot() != 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (c_FRAME + 4) tick();

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 9) == 0) rand_digits();
            if ($urandom_range(0, 119) == 0) alarm = ~alarm;
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
